// File: rtl/fp_pkg.sv
// Shared single-precision constants, converter FSM states and the packing helper.
// Used by both the integer-to-float converter and the FP add datapath.
package fp_pkg;

    localparam int unsigned SP_EXP_W  = 8;
    localparam int unsigned SP_FRAC_W = 23;
    localparam int unsigned SP_BIAS   = 127;
    localparam int unsigned SP_W      = 1 + SP_EXP_W + SP_FRAC_W;
    localparam int unsigned INT_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic                 sign;
        logic [SP_EXP_W-1:0]  exp_f;
        logic [SP_FRAC_W-1:0] frac;
    } sp_t;

    function automatic sp_t sp_pack(input logic                 sign,
                                    input logic [SP_EXP_W-1:0]  exp_v,
                                    input logic [SP_FRAC_W-1:0] frac);
        sp_t r;
        r.sign  = sign;
        r.exp_f = exp_v;
        r.frac  = frac;
        return r;
    endfunction

endpackage

// File: rtl/int2fp_norm.sv
// Magnitude/exponent shift registers for the integer-to-float converter.
// Captures sign and magnitude on load, shifts one bit per cycle until the MSB is set.
module int2fp_norm
    import fp_pkg::*;
#(
    parameter int unsigned EXP_BIAS = SP_BIAS,
    parameter int unsigned IN_W     = INT_W,
    parameter int unsigned EXP_W    = SP_EXP_W,
    parameter int unsigned FRAC_W   = SP_FRAC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic [IN_W-1:0] data_i,
    input  logic            signed_i,
    output logic            load_zero_o,
    output logic            lead_one_o,
    output sp_t             result_o,
    output logic            inexact_o
);

    logic             sign_d, sign_q;
    logic [IN_W-1:0]  mag_d, mag_q;
    logic [EXP_W-1:0] exp_q;

    // Two's complement negate; the most negative value maps onto itself as unsigned.
    always_comb begin
        sign_d = signed_i & data_i[IN_W-1];
        mag_d  = sign_d ? (~data_i + IN_W'(1)) : data_i;
    end

    assign load_zero_o = (mag_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            exp_q  <= '0;
        end else if (load_i) begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            exp_q  <= EXP_W'(EXP_BIAS + IN_W - 1);
        end else if (shift_i) begin
            mag_q  <= mag_q << 1;
            exp_q  <= exp_q - EXP_W'(1);
        end
    end

    // Hidden bit is mag_q[IN_W-1]; everything below the stored fraction is truncated.
    assign lead_one_o = mag_q[IN_W-1];
    assign result_o   = sp_pack(sign_q, exp_q, mag_q[IN_W-2 -: FRAC_W]);
    assign inexact_o  = |mag_q[IN_W-FRAC_W-2:0];

endmodule

// File: rtl/int_to_fp_seq.sv
// Multi-cycle 32-bit integer to single-precision converter with valid/ready on both sides.
// Normalises one bit per cycle and truncates toward zero.
module int_to_fp_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_BIAS = SP_BIAS,
    parameter int unsigned IN_W     = INT_W,
    parameter int unsigned EXP_W    = SP_EXP_W,
    parameter int unsigned FRAC_W   = SP_FRAC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SP_W-1:0] out_data,
    output logic            inexact
);

    state_e state_d, state_q;
    sp_t    out_data_d, out_data_q;
    logic   inexact_d, inexact_q;
    logic   out_valid_d, out_valid_q;
    logic   in_ready_d, in_ready_q;
    logic   load, shift;
    logic   load_zero, lead_one, norm_inexact;
    sp_t    norm_result;

    int2fp_norm #(
        .EXP_BIAS (EXP_BIAS),
        .IN_W     (IN_W),
        .EXP_W    (EXP_W),
        .FRAC_W   (FRAC_W)
    ) u_norm (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .shift_i     (shift),
        .data_i      (in_data),
        .signed_i    (in_signed),
        .load_zero_o (load_zero),
        .lead_one_o  (lead_one),
        .result_o    (norm_result),
        .inexact_o   (norm_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            inexact_q   <= inexact_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Handshake flags are decoded from the next state so they track state_q exactly.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        inexact_d  = inexact_q;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    if (load_zero) begin
                        out_data_d = '0;
                        inexact_d  = 1'b0;
                        state_d    = DONE;
                    end else begin
                        state_d    = NORM;
                    end
                end
            end
            NORM: begin
                if (lead_one) begin
                    out_data_d = norm_result;
                    inexact_d  = norm_inexact;
                    state_d    = DONE;
                end else begin
                    shift      = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Self-checking bench for int_to_fp_seq: table vectors, random vectors against a
// reference conversion, backpressure and mid-normalisation reset sequences.
module tb_int_to_fp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        inexact;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic        inexact;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic [31:0] ed;
        logic        ex;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];

    int_to_fp_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Independent reference: truncating conversion via leading-one search.
    function automatic exp_t model(input logic [31:0] d, input logic s);
        exp_t        e;
        logic        sg;
        logic [31:0] m;
        int          lz;
        sg = s & d[31];
        m  = sg ? (32'd0 - d) : d;
        lz = 0;
        if (m == 32'd0) begin
            e.data = 32'd0; e.inexact = 1'b0; e.lat = 0;
            return e;
        end
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) break;
            lz++;
        end
        m = m << lz;
        e.data    = {sg, 8'(158 - lz), m[30:8]};
        e.inexact = |m[7:0];
        e.lat     = 1 + lz;
        return e;
    endfunction

    // Wait for in_ready, present one operand for one accepting edge, then scramble inputs.
    task automatic drive(input logic [31:0] d, input logic s, input exp_t e);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = 1'($urandom_range(0, 1));
    endtask

    // Count edges from acceptance until out_valid, then compare against the scoreboard head.
    task automatic collect(input string name, input logic do_release);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({name, "_data"}, out_data, e.data);
        check({name, "_inexact"}, 32'(inexact), 32'(e.inexact));
        check({name, "_latency"}, 32'(lat), 32'(e.lat));
        if (do_release) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({name, "_ready_rise"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] held;
        logic [31:0] rd;
        logic        rs;

        vecs[0]  = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 32};
        vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 32};
        vecs[2]  = '{32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 1'b1, 1};
        vecs[3]  = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 1};
        vecs[4]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 0};
        vecs[5]  = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 8};
        vecs[6]  = '{32'h0000_0300, 1'b0, 32'h4440_0000, 1'b0, 23};
        vecs[7]  = '{32'h7FFF_FFFF, 1'b1, 32'h4EFF_FFFF, 1'b1, 2};
        vecs[8]  = '{32'hFFFF_FF00, 1'b1, 32'hC380_0000, 1'b0, 24};
        vecs[9]  = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 1};
        vecs[10] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_inexact", 32'(inexact), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            e.data = vecs[i].ed; e.inexact = vecs[i].ex; e.lat = vecs[i].lat;
            drive(vecs[i].d, vecs[i].s, e);
            collect($sformatf("vec%0d", i), 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            rd = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            drive(rd, rs, model(rd, rs));
            collect($sformatf("rand%0d", i), 1'b1);
        end

        // Backpressure: result held, busy block refuses a competing operand.
        e.data = 32'h4440_0000; e.inexact = 1'b0; e.lat = 23;
        drive(32'h0000_0300, 1'b0, e);
        collect("bp", 1'b0);
        held = out_data;
        in_valid = 1'b1;
        in_data  = 32'h0000_0005;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_stable%0d", c), out_data, 32'h4440_0000);
            check($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
            check($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
        end
        check("bp_held_match", out_data, held);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_extra_result", 32'(out_valid), 32'd0);

        // Reset during normalisation discards the in-flight result.
        e.data = 32'h3F80_0000; e.inexact = 1'b0; e.lat = 32;
        drive(32'h0000_0001, 1'b0, e);
        repeat (4) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_front());
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_inexact", 32'(inexact), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        e.data = 32'h4B80_0000; e.inexact = 1'b1; e.lat = 8;
        drive(32'h0100_0001, 1'b0, e);
        collect("post_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
